// File: rtl/decoder_sweep.sv
// decoder_sweep: registered one-hot decoder with an optional sweep mode.
//
// A single request (in_mode=0) decodes in_sel onto dec_out one cycle after
// it is accepted. A sweep request (in_mode=1) walks every code once. It
// starts at in_sel, increments modulo 2**SEL_W, and pulses sweep_done with
// the final code.
//
// Configuration macro: DECODER_SWEEP_EN
//    defined   -> SWEEP state, sweep counter and sweep_done are built
//    undefined -> in_mode is ignored, every accept is a single decode,
//                 busy and sweep_done are tied low
//
// Ports:
//    clk         sole clock, rising edge
//    rst         synchronous active-high reset (priority over en/in_valid)
//    en          global enable; low zeroes the outputs and freezes state
//    in_valid    request present
//    in_ready    combinational accept qualifier: en & !rst & idle
//    in_sel      code to decode, or sweep start code
//    in_mode     0 = single decode, 1 = sweep
//    dec_out     registered one-hot decode
//    out_valid   registered, high on the cycle a new code appears
//    busy        registered, high while sweeping
//    sweep_done  registered, pulses with the final sweep code
module decoder_sweep #(
   parameter int unsigned SEL_W = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_mode,
   output logic [(2**SEL_W)-1:0]   dec_out,
   output logic                    out_valid,
   output logic                    busy,
   output logic                    sweep_done
);

   localparam int unsigned OUT_W = 2**SEL_W;

`ifdef DECODER_SWEEP_EN

   localparam int unsigned CNT_W = SEL_W + 1;
   // The counter is one bit wider than the code so it can count all OUT_W codes.
   localparam logic [CNT_W-1:0] LAST = CNT_W'(OUT_W);

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;       // codes emitted so far in this sweep
   logic [SEL_W-1:0]   cur;       // next code to emit
   logic               busy_q;
   logic               done_q;

   assign in_ready   = en & ~rst & (state == IDLE);
   assign busy       = busy_q;
   assign sweep_done = done_q;

   // Control FSM and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         cur       <= '0;
         dec_out   <= '0;
         out_valid <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else if (!en) begin
         // Outputs go inactive; state, cnt and cur hold so the sweep resumes cleanly.
         dec_out   <= '0;
         out_valid <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         done_q    <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  dec_out   <= OUT_W'(1) << in_sel;
                  out_valid <= 1'b1;
                  if (in_mode) begin
                     // The first sweep code is emitted together with the accept.
                     state  <= SWEEP;
                     busy_q <= 1'b1;
                     cnt    <= CNT_W'(1);
                     cur    <= in_sel + SEL_W'(1);
                  end
               end
            end
            SWEEP: begin
               if (cnt == LAST) begin
                  // Last code already shown; dec_out keeps it.
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  cnt    <= '0;
               end else begin
                  dec_out   <= OUT_W'(1) << cur;
                  out_valid <= 1'b1;
                  cur       <= cur + SEL_W'(1);
                  cnt       <= cnt + CNT_W'(1);
                  done_q    <= (cnt == LAST - CNT_W'(1));
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`else

   logic unused_mode;
   assign unused_mode = in_mode;

   assign in_ready   = en & ~rst;
   assign busy       = 1'b0;
   assign sweep_done = 1'b0;

   // Single-decode only.
   always_ff @(posedge clk) begin
      if (rst) begin
         dec_out   <= '0;
         out_valid <= 1'b0;
      end else if (!en) begin
         dec_out   <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (in_valid) begin
            dec_out   <= OUT_W'(1) << in_sel;
            out_valid <= 1'b1;
         end
      end
   end

`endif

endmodule

// File: tb/tb_decoder_sweep.sv
// Directed testbench for decoder_sweep with SEL_W=3. Inputs change 1 time
// unit after the rising edge. Outputs are checked at the same point.
module tb_decoder_sweep;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_sel;
   logic       in_mode;
   logic [7:0] dec_out;
   logic       out_valid;
   logic       busy;
   logic       sweep_done;

   int tests  = 0;
   int errors = 0;

   always #5 clk = ~clk;

   decoder_sweep #(.SEL_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sel     (in_sel),
      .in_mode    (in_mode),
      .dec_out    (dec_out),
      .out_valid  (out_valid),
      .busy       (busy),
      .sweep_done (sweep_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

`ifdef DECODER_SWEEP_EN
   logic [7:0] exp6 [8] = '{8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
   logic [7:0] exp0 [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
`endif

   initial begin
      rst = 1'b1; en = 1'b1; in_valid = 1'b1; in_sel = 3'd3; in_mode = 1'b0;

      // Reset held 2 cycles with a pending request.
      tick(); tick();
      chk("rst_dec", 32'(dec_out), 32'h00);
      chk("rst_ov", 32'(out_valid), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(sweep_done), 32'd0);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("rel_ready", 32'(in_ready), 32'd1);

      // Single decode of 5.
      in_sel = 3'd5; in_mode = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("single_dec", 32'(dec_out), 32'h20);
      chk("single_ov", 32'(out_valid), 32'd1);
      tick();
      chk("hold_dec", 32'(dec_out), 32'h20);
      chk("hold_ov", 32'(out_valid), 32'd0);
      tick();
      chk("hold2_dec", 32'(dec_out), 32'h20);

      // Back-to-back singles at both code extremes.
      in_sel = 3'd0; in_valid = 1'b1;
      tick();
      chk("b2b0_dec", 32'(dec_out), 32'h01);
      in_sel = 3'd7;
      tick();
      in_valid = 1'b0;
      chk("b2b7_dec", 32'(dec_out), 32'h80);
      chk("b2b7_ov", 32'(out_valid), 32'd1);

      // en low zeroes outputs and blocks accepts.
      en = 1'b0; in_valid = 1'b1; in_sel = 3'd4;
      #1;
      chk("en0_ready", 32'(in_ready), 32'd0);
      tick();
      chk("en0_dec", 32'(dec_out), 32'h00);
      chk("en0_ov", 32'(out_valid), 32'd0);
      en = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("en1_dec", 32'(dec_out), 32'h10);

`ifdef DECODER_SWEEP_EN
      // Sweep from 6; requests during the sweep are ignored.
      tick();
      in_sel = 3'd6; in_mode = 1'b1; in_valid = 1'b1;
      tick();
      in_sel = 3'd1; in_mode = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("sw6_dec", 32'(dec_out), 32'(exp6[i]));
         chk("sw6_ov", 32'(out_valid), 32'd1);
         chk("sw6_busy", 32'(busy), 32'd1);
         chk("sw6_ready", 32'(in_ready), 32'd0);
         chk("sw6_done", 32'(sweep_done), (i == 7) ? 32'd1 : 32'd0);
         if (i == 7) in_valid = 1'b0;
         tick();
      end
      chk("sw6_end_busy", 32'(busy), 32'd0);
      chk("sw6_end_dec", 32'(dec_out), 32'h20);
      chk("sw6_end_ov", 32'(out_valid), 32'd0);
      chk("sw6_end_done", 32'(sweep_done), 32'd0);
      chk("sw6_end_ready", 32'(in_ready), 32'd1);

      // Sweep from 0 with a 2-cycle pause after code 04.
      in_sel = 3'd0; in_mode = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("pz_pre_dec", 32'(dec_out), 32'(exp0[i]));
         if (i < 2) tick();
      end
      en = 1'b0;
      tick();
      chk("pz_dec", 32'(dec_out), 32'h00);
      chk("pz_ov", 32'(out_valid), 32'd0);
      chk("pz_busy", 32'(busy), 32'd1);
      tick();
      chk("pz2_dec", 32'(dec_out), 32'h00);
      en = 1'b1;
      tick();
      for (int i = 3; i < 8; i++) begin
         chk("pz_post_dec", 32'(dec_out), 32'(exp0[i]));
         chk("pz_post_done", 32'(sweep_done), (i == 7) ? 32'd1 : 32'd0);
         tick();
      end
      chk("pz_end_busy", 32'(busy), 32'd0);
      chk("pz_end_dec", 32'(dec_out), 32'h80);

      // Abort with rst after three codes.
      in_sel = 3'd0; in_mode = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      chk("ab_pre_dec", 32'(dec_out), 32'h04);
      rst = 1'b1;
      #1;
      chk("ab_ready", 32'(in_ready), 32'd0);
      tick();
      chk("ab_dec", 32'(dec_out), 32'h00);
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_done", 32'(sweep_done), 32'd0);
      rst = 1'b0;
      tick();
      chk("ab_idle_done", 32'(sweep_done), 32'd0);
      in_sel = 3'd1; in_mode = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("ab_single_dec", 32'(dec_out), 32'h02);
      chk("ab_single_ov", 32'(out_valid), 32'd1);
      chk("ab_single_busy", 32'(busy), 32'd0);
`else
      // in_mode is ignored: a sweep request is a single decode.
      tick();
      in_sel = 3'd2; in_mode = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("moff_dec", 32'(dec_out), 32'h04);
      chk("moff_ov", 32'(out_valid), 32'd1);
      chk("moff_busy", 32'(busy), 32'd0);
      chk("moff_done", 32'(sweep_done), 32'd0);
      chk("moff_ready", 32'(in_ready), 32'd1);
      tick();
      chk("moff_hold_dec", 32'(dec_out), 32'h04);
      chk("moff_hold_ov", 32'(out_valid), 32'd0);
      chk("moff_hold_busy", 32'(busy), 32'd0);
`endif

      // Reset wins over a simultaneous request.
      rst = 1'b1; in_valid = 1'b1; in_sel = 3'd6; in_mode = 1'b0;
      tick();
      chk("rstpri_dec", 32'(dec_out), 32'h00);
      chk("rstpri_ov", 32'(out_valid), 32'd0);
      rst = 1'b0; in_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
